// File: rtl/inv_sqrt_sched_pkg.sv
// Fixed-point types, constants and arithmetic helpers shared by the
// inverse-square-root scheduler and its Newton-Raphson step datapath.
package inv_sqrt_sched_pkg;

    // Q16.16 signed fixed point
    localparam int FRAC_BITS = 16;

    // Iteration counter width, large enough for up to 15 iterations
    localparam int CNT_W = 4;

    typedef logic signed [31:0] fix_t;

    localparam fix_t FIX_ONE    = fix_t'(1 << FRAC_BITS);
    localparam fix_t THREEHALFS = fix_t'(3 << (FRAC_BITS - 1));
    localparam fix_t FIX_MAX    = 32'sh7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        ITER,
        DONE
    } state_t;

    // Signed fixed-point multiply; the low fraction bits are truncated
    // (arithmetic shift, so rounding is toward minus infinity).
    function automatic fix_t mult(input fix_t a, input fix_t b);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return fix_t'(prod >>> FRAC_BITS);
    endfunction

    // Initial guess from the leading one of x (bits 30..1). For x in
    // [2^e, 2^(e+1)) the guess is 2^-ceil(e/2), which keeps g*g*x below 2
    // so Newton iteration converges monotonically. Non-positive operands
    // and x with only bit 0 set fall back to 1.0.
    function automatic fix_t seed(input fix_t x);
        fix_t g;
        int   pos;
        g   = FIX_ONE;
        pos = FRAC_BITS;
        if (x > 0) begin
            for (int p = 1; p <= 30; p++) begin
                if (x[p]) begin
                    pos = FRAC_BITS + ((FRAC_BITS - p) >>> 1);
                    g   = fix_t'(1) <<< pos;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/inv_sqrt_step.sv
// One combinational Newton-Raphson step for 1/sqrt(x):
// g' = g * (1.5 - (x/2) * g * g), all products truncating Q16.16.
module inv_sqrt_step
    import inv_sqrt_sched_pkg::*;
(
    input  logic [31:0] guess_i,
    input  logic [31:0] x_i,
    output logic [31:0] next_o
);

    fix_t guess;
    fix_t x;
    fix_t sq;
    fix_t halfX;
    fix_t corr;

    assign guess  = $signed(guess_i);
    assign x      = $signed(x_i);
    assign sq     = mult(guess, guess);
    assign halfX  = x >>> 1;
    assign corr   = THREEHALFS - mult(halfX, sq);
    assign next_o = mult(guess, corr);

endmodule

// File: rtl/inv_sqrt_sched.sv
// Shared iterative inverse-square-root engine. Round-robin arbitration
// between requesters, then a single registered Newton step is reused
// ITERS times before the result is presented with a valid/ready handshake.
module inv_sqrt_sched
    import inv_sqrt_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ITERS = 10,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][31:0] req_x,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   rsp_err
);

    state_t           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    fix_t             x_q;
    logic [ID_W-1:0]  id_q;
    fix_t             guess_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    fix_t             rsp_result_q;
    logic             rsp_err_q;

    logic [31:0]      guess_d;
    logic [N_REQ-1:0] grant_vec;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;

    inv_sqrt_step u_step (
        .guess_i (guess_q),
        .x_i     (x_q),
        .next_o  (guess_d)
    );

    // Round-robin search for the first valid requester starting at rr_ptr
    always_comb begin
        int idx;
        idx       = 0;
        grant_vec = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any      = 1'b1;
                grant_id       = ID_W'(idx);
                grant_vec[idx] = 1'b1;
            end
        end
    end

    // Ready only in IDLE and held low while reset is asserted
    assign req_ready  = (state_q == IDLE && rst_n) ? grant_vec : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

    // Scheduler FSM: accept, seed, iterate, then hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            x_q          <= '0;
            id_q         <= '0;
            guess_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        x_q      <= $signed(req_x[grant_id]);
                        id_q     <= grant_id;
                        rr_ptr_q <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                        state_q  <= SEED;
                    end
                end
                SEED: begin
                    guess_q <= seed(x_q);
                    err_q   <= (x_q <= 32'sd0);
                    cnt_q   <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    guess_q <= guess_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_q      <= DONE;
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= id_q;
                        rsp_err_q    <= err_q;
                        rsp_result_q <= err_q ? FIX_MAX : $signed(guess_d);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q      <= IDLE;
                        rsp_valid_q  <= 1'b0;
                        rsp_id_q     <= '0;
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
